mem_access: RTL and testbench

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. It turns the load/store micro-op latched by EX/MEM into a single request/acknowledge transaction on the data bus and raises a stall request while the transaction is outstanding. It formats load data with sign/zero extension and maintains the LL/SC link bit. Non-memory instructions pass through combinationally with no added latency.

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_access.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-bus request/acknowledge bundle between the MEM stage and memory
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: load/store bus transaction, load formatting, LL/SC link bit
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         llbit_clr,
  input  logic [4:0]   ex_wd,
  input  logic         ex_wreg,
  input  logic [31:0]  ex_wdata,
  input  logic         ex_whilo,
  input  logic [31:0]  ex_hi,
  input  logic [31:0]  ex_lo,
  input  logic [7:0]   ex_aluop,
  input  logic [31:0]  ex_mem_addr,
  input  logic [31:0]  ex_reg2,
  output logic [4:0]   wb_wd,
  output logic         wb_wreg,
  output logic [31:0]  wb_wdata,
  output logic         wb_whilo,
  output logic [31:0]  wb_hi,
  output logic [31:0]  wb_lo,
  output logic         stallreq,
  output logic         llbit,
  mem_access_if.master bus
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state, state_nxt;
  size_t       size;
  logic        is_mem, is_load, is_store, is_ll, is_sc, ld_signed;
  logic        sc_fail, start, ack_hit;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  logic        req_q, we_q, llbit_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;

  always_comb begin
    is_mem    = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ll     = 1'b0;
    is_sc     = 1'b0;
    ld_signed = 1'b0;
    size      = SZ_W;
    case (ex_aluop)
      OP_LB:   begin is_load = 1'b1; ld_signed = 1'b1; size = SZ_B; end
      OP_LH:   begin is_load = 1'b1; ld_signed = 1'b1; size = SZ_H; end
      OP_LW:   is_load = 1'b1;
      OP_LBU:  begin is_load = 1'b1; size = SZ_B; end
      OP_LHU:  begin is_load = 1'b1; size = SZ_H; end
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      OP_SW:   is_store = 1'b1;
      OP_LL:   begin is_load = 1'b1; is_ll = 1'b1; end
      OP_SC:   begin is_store = 1'b1; is_sc = 1'b1; end
      default: is_mem = 1'b0;
    endcase
  end

  // SC failure is decided at issue; once the write is on the bus it completes as a success
  assign sc_fail = is_sc && !llbit_q && (state == ST_IDLE);
  assign start   = (state == ST_IDLE) && is_mem && !sc_fail;
  assign ack_hit = (state == ST_BUSY) && bus.bus_ack;

  // Big-endian lanes: byte 0 of the word lives in bits [31:24]
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = ex_reg2;
    case (size)
      SZ_B: begin
        wdata_nxt = {4{ex_reg2[7:0]}};
        case (ex_mem_addr[1:0])
          2'd0:    sel_nxt = 4'b1000;
          2'd1:    sel_nxt = 4'b0100;
          2'd2:    sel_nxt = 4'b0010;
          default: sel_nxt = 4'b0001;
        endcase
      end
      SZ_H: begin
        wdata_nxt = {2{ex_reg2[15:0]}};
        sel_nxt   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)   state_nxt = ST_BUSY;
      ST_BUSY: if (ack_hit) state_nxt = ST_DONE;
      ST_DONE: if (!hold)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else if (start) begin
      req_q   <= 1'b1;
      we_q    <= is_store;
      addr_q  <= {ex_mem_addr[31:2], 2'b00};
      sel_q   <= sel_nxt;
      wdata_q <= wdata_nxt;
    end else if (ack_hit) begin
      req_q   <= 1'b0;
      rdata_q <= bus.bus_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    llbit_q <= 1'b0;
    else if (llbit_clr)         llbit_q <= 1'b0;
    else if (ack_hit && is_ll)  llbit_q <= 1'b1;
    else if (ack_hit && is_sc)  llbit_q <= 1'b0;
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_wdata = wdata_q;

  always_comb begin
    lane_b = 8'h00;
    case (ex_mem_addr[1:0])
      2'd0:    lane_b = rdata_q[31:24];
      2'd1:    lane_b = rdata_q[23:16];
      2'd2:    lane_b = rdata_q[15:8];
      default: lane_b = rdata_q[7:0];
    endcase
    lane_h    = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    load_data = rdata_q;
    case (size)
      SZ_B:    load_data = ld_signed ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      SZ_H:    load_data = ld_signed ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    wb_wdata = ex_wdata;
    if (is_sc)
      wb_wdata = {31'h0, state == ST_DONE};
    else if (is_load && state == ST_DONE)
      wb_wdata = load_data;
  end

  assign stallreq = is_mem && (state != ST_DONE) && !sc_fail;
  assign llbit    = llbit_q;
  assign wb_wd    = ex_wd;
  assign wb_wreg  = ex_wreg;
  assign wb_whilo = ex_whilo;
  assign wb_hi    = ex_hi;
  assign wb_lo    = ex_lo;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - bench for mem_access: vector table, LL/SC and reset sequences, random ops vs model
module tb_mem_access;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, llbit_clr;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_whilo, stallreq, llbit;
  logic [31:0] wb_wdata, wb_hi, wb_lo;

  mem_access_if bus_if ();

  mem_access dut (
    .clk(clk), .rst(rst), .hold(hold), .llbit_clr(llbit_clr),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .stallreq(stallreq), .llbit(llbit), .bus(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_ll;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Reference model: access size in bytes, byte offset in the word, big-endian lanes
  function automatic int m_size(input logic [7:0] op);
    case (op)
      8'hE0, 8'hE4, 8'hE8:        return 1;
      8'hE1, 8'hE5, 8'hE9:        return 2;
      8'hE3, 8'hEB, 8'hF0, 8'hF8: return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return op == 8'hE8 || op == 8'hE9 || op == 8'hEB || op == 8'hF8;
  endfunction

  function automatic int m_off(input logic [7:0] op, input logic [31:0] a);
    int sz = m_size(op);
    if (sz == 4) return 0;
    if (sz == 2) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    int sz = m_size(op);
    int v  = ((1 << sz) - 1) << (4 - sz - m_off(op, a));
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_bwdata(input logic [7:0] op, input logic [31:0] r2);
    case (m_size(op))
      1:       return {24'h0, r2[7:0]} * 32'h01010101;
      2:       return {16'h0, r2[15:0]} * 32'h00010001;
      default: return r2;
    endcase
  endfunction

  function automatic logic [31:0] m_result(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd, input logic [31:0] wd, input bit llb);
    int sz = m_size(op);
    logic [31:0] mask, v;
    if (sz == 0) return wd;
    if (op == 8'hF8) return llb ? 32'h1 : 32'h0;
    if (m_is_store(op)) return wd;
    mask = (sz == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v = (rd >> (8 * (4 - sz - m_off(op, a)))) & mask;
    if ((op == 8'hE0 || op == 8'hE1) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                     input logic [31:0] reg2, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int ack_cyc, input int hold_n, input bit clr_on_ack,
                     input bit e_iss, input bit e_we, input logic [3:0] e_sel,
                     input logic [31:0] e_bwd, input logic [31:0] e_res, input bit e_ll);
    logic [31:0] hi_v, lo_v;
    @(negedge clk);
    hi_v = $urandom;
    lo_v = $urandom;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wdata = wdata;
    ex_hi = hi_v; ex_lo = lo_v; ex_whilo = hi_v[0]; ex_wd = lo_v[4:0]; ex_wreg = lo_v[5];
    #1;
    chkb({tag, " stall_c0"}, stallreq, e_iss);
    chk({tag, " wb_hi"}, wb_hi, hi_v);
    chk({tag, " wb_lo"}, wb_lo, lo_v);
    chk({tag, " wb_wd"}, {26'h0, wb_wreg, wb_wd}, {26'h0, lo_v[5:0]});
    chkb({tag, " wb_whilo"}, wb_whilo, hi_v[0]);
    if (!e_iss) begin
      chkb({tag, " no_req"}, bus_if.bus_req, 1'b0);
      chk({tag, " wdata"}, wb_wdata, e_res);
    end else begin
      chkb({tag, " req_c0"}, bus_if.bus_req, 1'b0);
      @(negedge clk); #1;
      chkb({tag, " req_c1"}, bus_if.bus_req, 1'b1);
      chkb({tag, " we"}, bus_if.bus_we, e_we);
      chk({tag, " addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
      chk({tag, " sel"}, {28'h0, bus_if.bus_sel}, {28'h0, e_sel});
      if (e_we) chk({tag, " bus_wdata"}, bus_if.bus_wdata, e_bwd);
      chkb({tag, " stall_c1"}, stallreq, 1'b1);
      for (int c = 2; c <= ack_cyc; c++) begin
        @(negedge clk); #1;
        chkb({tag, " stall_wait"}, stallreq, 1'b1);
        chk({tag, " addr_stable"}, bus_if.bus_addr, {addr[31:2], 2'b00});
      end
      bus_if.bus_rdata = rdata;
      bus_if.bus_ack   = 1'b1;
      llbit_clr        = clr_on_ack;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      llbit_clr      = 1'b0;
      hold           = (hold_n > 0);
      #1;
      chkb({tag, " stall_done"}, stallreq, 1'b0);
      chkb({tag, " req_done"}, bus_if.bus_req, 1'b0);
      chk({tag, " result"}, wb_wdata, e_res);
      for (int h = 0; h < hold_n; h++) begin
        @(negedge clk); #1;
        chkb({tag, " hold_stall"}, stallreq, 1'b0);
        chk({tag, " hold_result"}, wb_wdata, e_res);
      end
      hold = 1'b0;
    end
    chkb({tag, " llbit"}, llbit, e_ll);
    @(posedge clk); #1;
    ex_aluop = 8'h00;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, wdata, rdata;
    int          ack, hold_n;
    bit          iss, we;
    logic [3:0]  sel;
    logic [31:0] bwd, res;
  } vec_t;

  vec_t vec[13];
  logic [7:0] ops[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r_op;
    logic [31:0] r_addr, r_reg2, r_wd, r_rd;
    bit          r_iss, r_clr, r_ll;

    vec[0]  = '{8'h21, 32'h0,   32'h0,        32'h1234, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0,        32'h1234};
    vec[1]  = '{8'hE0, 32'h103, 32'h0,        32'h5555, 32'h112233F0, 2, 0, 1, 0, 4'b0001, 32'h0,        32'hFFFFFFF0};
    vec[2]  = '{8'hE4, 32'h103, 32'h0,        32'h5555, 32'h112233F0, 2, 0, 1, 0, 4'b0001, 32'h0,        32'h000000F0};
    vec[3]  = '{8'hE9, 32'h202, 32'hAAAABEEF, 32'h7777, 32'h0,        1, 0, 1, 1, 4'b0011, 32'hBEEFBEEF, 32'h7777};
    vec[4]  = '{8'hE1, 32'h100, 32'h0,        32'h0,    32'h80011234, 3, 0, 1, 0, 4'b1100, 32'h0,        32'hFFFF8001};
    vec[5]  = '{8'hE5, 32'h103, 32'h0,        32'h0,    32'h00009ABC, 1, 0, 1, 0, 4'b0011, 32'h0,        32'h00009ABC};
    vec[6]  = '{8'hE3, 32'h1FF, 32'h0,        32'h0,    32'hDEADBEEF, 1, 2, 1, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vec[7]  = '{8'hE8, 32'h001, 32'h123456A5, 32'h99,   32'h0,        2, 0, 1, 1, 4'b0100, 32'hA5A5A5A5, 32'h99};
    vec[8]  = '{8'hEB, 32'h300, 32'h01020304, 32'hABCD, 32'h0,        4, 1, 1, 1, 4'b1111, 32'h01020304, 32'hABCD};
    vec[9]  = '{8'hE0, 32'h100, 32'h0,        32'h0,    32'h7F000000, 1, 0, 1, 0, 4'b1000, 32'h0,        32'h0000007F};
    vec[10] = '{8'hE5, 32'h000, 32'h0,        32'h0,    32'hF00DCAFE, 1, 0, 1, 0, 4'b1100, 32'h0,        32'h0000F00D};
    vec[11] = '{8'hE1, 32'h002, 32'h0,        32'h0,    32'h1234FEDC, 2, 0, 1, 0, 4'b0011, 32'h0,        32'hFFFFFEDC};
    vec[12] = '{8'hE0, 32'h101, 32'h0,        32'h0,    32'h00800000, 1, 0, 1, 0, 4'b0100, 32'h0,        32'hFFFFFF80};
    ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB, 8'hF0, 8'hF8, 8'h21};

    rst = 1'b1; hold = 1'b0; llbit_clr = 1'b0;
    ex_wd = 5'h0; ex_wreg = 1'b0; ex_wdata = 32'h0; ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0;
    ex_aluop = 8'h00; ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
    bus_if.bus_rdata = 32'h0; bus_if.bus_ack = 1'b0;
    model_ll = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chkb("rst bus_req", bus_if.bus_req, 1'b0);
    chkb("rst bus_we", bus_if.bus_we, 1'b0);
    chk("rst bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst bus_sel", {28'h0, bus_if.bus_sel}, 32'h0);
    chk("rst bus_wdata", bus_if.bus_wdata, 32'h0);
    chkb("rst llbit", llbit, 1'b0);
    chkb("rst stallreq", stallreq, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      txn($sformatf("vec%0d", i), vec[i].op, vec[i].addr, vec[i].reg2, vec[i].wdata, vec[i].rdata,
          vec[i].ack, vec[i].hold_n, 1'b0, vec[i].iss, vec[i].we, vec[i].sel, vec[i].bwd, vec[i].res, 1'b0);

    // LL/SC pairing, failing SC, and a link clear racing an LL completion
    txn("ll",      8'hF0, 32'h40, 32'h0,    32'h0,    32'h55, 1, 0, 1'b0, 1, 0, 4'b1111, 32'h0,    32'h55, 1'b1);
    txn("sc_ok",   8'hF8, 32'h40, 32'h600D, 32'h3333, 32'h0,  2, 0, 1'b0, 1, 1, 4'b1111, 32'h600D, 32'h1,  1'b0);
    txn("sc_fail", 8'hF8, 32'h40, 32'h600D, 32'h3333, 32'h0,  1, 0, 1'b0, 0, 0, 4'b0000, 32'h0,    32'h0,  1'b0);
    txn("ll_clr",  8'hF0, 32'h44, 32'h0,    32'h0,    32'h66, 2, 0, 1'b1, 1, 0, 4'b1111, 32'h0,    32'h66, 1'b0);

    @(negedge clk);
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chkb("stray_ack req", bus_if.bus_req, 1'b0);
    chkb("stray_ack stall", stallreq, 1'b0);

    // Reset in the middle of an outstanding LW, with the link bit set beforehand
    txn("ll_pre",  8'hF0, 32'h80, 32'h0, 32'h0, 32'h77, 1, 0, 1'b0, 1, 0, 4'b1111, 32'h0, 32'h77, 1'b1);
    @(negedge clk);
    ex_aluop = 8'hE3; ex_mem_addr = 32'h500;
    @(negedge clk); #1;
    chkb("rstbusy req_before", bus_if.bus_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkb("rstbusy req_async", bus_if.bus_req, 1'b0);
    chk("rstbusy addr", bus_if.bus_addr, 32'h0);
    chkb("rstbusy llbit", llbit, 1'b0);
    @(negedge clk);
    rst = 1'b0; ex_aluop = 8'h00;
    bus_if.bus_rdata = 32'hBADBAD00; bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chkb("rstbusy ack_ignored req", bus_if.bus_req, 1'b0);
    chkb("rstbusy ack_ignored stall", stallreq, 1'b0);
    chkb("rstbusy ack_ignored llbit", llbit, 1'b0);
    model_ll = 1'b0;
    txn("post_rst", vec[9].op, vec[9].addr, vec[9].reg2, vec[9].wdata, vec[9].rdata, 1, 0, 1'b0,
        1, 0, vec[9].sel, 32'h0, vec[9].res, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r_op   = ops[$urandom_range(0, 10)];
      r_addr = $urandom;
      r_reg2 = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_iss  = (m_size(r_op) != 0) && !(r_op == 8'hF8 && !model_ll);
      r_clr  = r_iss && ($urandom_range(0, 7) == 0);
      if (r_clr)                      r_ll = 1'b0;
      else if (r_iss && r_op == 8'hF0) r_ll = 1'b1;
      else if (r_iss && r_op == 8'hF8) r_ll = 1'b0;
      else                            r_ll = model_ll;
      txn($sformatf("rnd%0d op%h", i, r_op), r_op, r_addr, r_reg2, r_wd, r_rd,
          int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), r_clr,
          r_iss, m_is_store(r_op), m_sel(r_op, r_addr), m_bwdata(r_op, r_reg2),
          m_result(r_op, r_addr, r_rd, r_wd, model_ll), r_ll);
      model_ll = r_ll;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
